// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// reg_file : 32 x XLEN RISC-V integer register file, 2 async reads, 1 sync write
// Revision : 1.0
// ============================================================================
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] DataD,
    input  logic [31:0]     inst,
    input  logic            RegWEn,
    output logic [XLEN-1:0] DataA,
    output logic [XLEN-1:0] DataB
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   rd;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;

    assign rd  = inst[7  +: AW];
    assign rs1 = inst[15 +: AW];
    assign rs2 = inst[20 +: AW];

    // An X on RegWEn takes the else path in simulation, so no entry is touched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWEn && (rd != '0)) begin
            regs[rd] <= DataD;
        end
    end

    // x0 is forced to zero at the read mux, independent of what storage holds.
    assign DataA = (rs1 == '0) ? '0 : regs[rs1];
    assign DataB = (rs2 == '0) ? '0 : regs[rs2];

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// tb_reg_file : table-driven, scoreboard-checked bench for reg_file
// Revision    : 1.0
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic [31:0] DataD;
    logic [31:0] inst;
    logic        RegWEn;
    logic [31:0] DataA;
    logic [31:0] DataB;

    int checks;
    int failures;

    reg_file #(.XLEN(32), .NREG(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .DataD  (DataD),
        .inst   (inst),
        .RegWEn (RegWEn),
        .DataA  (DataA),
        .DataB  (DataB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] dd;
        logic        we;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    exp_t sb[$];

    function automatic logic [31:0] mk(input int rdi, input int r1, input int r2);
        logic [4:0] a, b, c;
        a = rdi[4:0];
        b = r1[4:0];
        c = r2[4:0];
        return {7'b0, c, b, 3'b000, a, 7'h33};
    endfunction

    function automatic logic [31:0] sweep_val(input int i);
        return (i == 0) ? 32'd0 : 32'(i * 3 + 1);
    endfunction

    task automatic check_pop();
        exp_t e;
        if (sb.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL scoreboard_empty");
        end else begin
            e = sb.pop_front();
            checks++;
            if (DataA !== e.exp_a || DataB !== e.exp_b) begin
                failures++;
                $display("FAIL %s: DataA=%h DataB=%h expected DataA=%h DataB=%h",
                         e.name, DataA, DataB, e.exp_a, e.exp_b);
            end
        end
    endtask

    // Drive on the falling edge, compare 1ns later (before the write edge).
    task automatic drive(input string nm, input logic [31:0] in, input logic [31:0] d,
                         input logic we, input logic [31:0] ea, input logic [31:0] eb);
        exp_t e;
        @(negedge clk);
        inst   = in;
        DataD  = d;
        RegWEn = we;
        e.name = nm; e.exp_a = ea; e.exp_b = eb;
        sb.push_back(e);
        #1;
        check_pop();
    endtask

    vec_t vecs[10];

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;

        vecs[0] = '{"write_x8",      32'h00E60433, 32'd100,       1'b1,  32'd0,   32'd0};
        vecs[1] = '{"read_x8_x8",    32'h00840433, 32'd55,        1'b0,  32'd100, 32'd100};
        vecs[2] = '{"wen0_hold",     32'h00840433, 32'd55,        1'b0,  32'd100, 32'd100};
        vecs[3] = '{"x0_write",      mk(0, 8, 0),  32'hDEADBEEF,  1'b1,  32'd100, 32'd0};
        vecs[4] = '{"x0_read",       mk(0, 0, 0),  32'd0,         1'b0,  32'd0,   32'd0};
        vecs[5] = '{"setup_x5",      mk(5, 8, 5),  32'd7,         1'b1,  32'd100, 32'd0};
        vecs[6] = '{"rdw_before",    mk(5, 5, 8),  32'd9,         1'b1,  32'd7,   32'd100};
        vecs[7] = '{"rdw_after",     mk(0, 5, 5),  32'd0,         1'b0,  32'd9,   32'd9};
        vecs[8] = '{"wen_x",         mk(8, 8, 5),  32'd123,       1'bx,  32'd100, 32'd9};
        vecs[9] = '{"wen_x_after",   mk(0, 8, 5),  32'd0,         1'b0,  32'd100, 32'd9};

        rst_n  = 1'b0;
        inst   = 32'h00E60433;
        DataD  = 32'd100;
        RegWEn = 1'b1;

        drive("reset_hold", 32'h00E60433, 32'd100, 1'b1, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive("reset_no_write", 32'h00E60433, 32'd0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].name, vecs[i].inst, vecs[i].dd, vecs[i].we,
                  vecs[i].exp_a, vecs[i].exp_b);
        end

        // Sweep writes; the read mux shows x0 on both ports while writing.
        for (int i = 1; i < 32; i++) begin
            drive("sweep_wr", mk(i, 0, 0), sweep_val(i), 1'b1, 32'd0, 32'd0);
        end
        for (int i = 0; i < 32; i++) begin
            drive("sweep_rd", mk(0, i, 31 - i), 32'd0, 1'b0,
                  sweep_val(i), sweep_val(31 - i));
        end

        // Asynchronous reset in the middle of a cycle with a write pending.
        @(negedge clk);
        inst   = mk(7, 3, 4);
        DataD  = 32'd77;
        RegWEn = 1'b1;
        e.name = "async_reset_mid"; e.exp_a = 32'd0; e.exp_b = 32'd0;
        sb.push_back(e);
        #2;
        rst_n = 1'b0;
        #1;
        check_pop();
        drive("reset_no_write_x7", mk(7, 7, 3), 32'd77, 1'b1, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive("post_reset_x7", mk(0, 7, 31), 32'd0, 1'b0, 32'd0, 32'd0);

        if (sb.size() != 0) begin
            failures++;
            checks++;
            $display("FAIL scoreboard_leftover: size=%0d expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
